cmp_window_stats: RTL and testbench
===================================

Name: cmp_window_stats

Overview:
- Downstream consumer of the 32-bit magnitude comparator (L/G/E flags).
- Collects comparator results over fixed windows of WIN_LEN accepted samples.
- Per window, reports less/greater/equal counts and the longest run of consecutive equal results.
- Window results leave through a valid/ready output handshake; input is back-pressured while a result is pending.

Parameters:
- WIN_LEN, 8, accepted samples per window; legal range 2..255.
- CNT_W, 8, width of each count output; must satisfy 2^CNT_W-1 >= WIN_LEN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; highest priority after reset.
- in_valid  in  1  comparator result present.
- in_ready  out  1  block accepts a result this cycle.
- L  in  1  comparator "a < b" flag.
- G  in  1  comparator "a > b" flag.
- E  in  1  comparator "a == b" flag.
- out_valid  out  1  window result held on outputs.
- out_ready  in  1  consumer takes the result.
- lt_cnt  out  CNT_W  L results in the window.
- gt_cnt  out  CNT_W  G results in the window.
- eq_cnt  out  CNT_W  E results in the window.
- eq_run_max  out  CNT_W  longest consecutive E run in the window.
- err_flag  out  1  sticky: some sample in the window was not one-hot.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State COLLECT.
  - All internal counters, sample index, and current-run register = 0.
  - Outputs: out_valid=0, all count outputs=0, err_flag=0, in_ready=1.
- States: COLLECT and HOLD.
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept (COLLECT, in_valid=1):
  - Exactly one of L/G/E high: increment the matching internal counter.
  - On E: cur_run += 1; run_max = max(run_max, cur_run+1) in the same cycle.
  - On L or G: cur_run = 0.
  - Flags not one-hot (none set, or more than one set): no count increments, cur_run = 0, err sticky set; the sample still counts toward WIN_LEN.
  - Sample index increments by 1.
- Window close:
  - The accept that brings the index to WIN_LEN loads lt_cnt, gt_cnt, eq_cnt, eq_run_max, and err_flag from the updated values, including that final sample.
  - Same edge: index, counters, cur_run, run_max, and err sticky are zeroed; state goes to HOLD.
  - out_valid rises the cycle after the last accept. Latency from last accept to out_valid = 1 clock.
- HOLD:
  - Outputs stable.
  - in_valid is ignored; no sample is consumed because in_ready=0.
  - When out_ready=1, return to COLLECT on the next edge. out_valid drops and in_ready rises in the same cycle.
  - Output registers keep their last values after the handshake; only out_valid qualifies them.
  - The earliest new accept is the cycle after the handshake. Throughput: WIN_LEN+1 cycles per window minimum.
- out_ready in COLLECT: no effect.
- clear=1 (synchronous, any state):
  - Next state COLLECT; everything returns to reset values, including output registers.
  - An in_valid in the same cycle is not counted, even though in_ready reads 1 in COLLECT.
  - clear overrides a coincident window close and a coincident handshake.
- Count outputs never exceed WIN_LEN, so no saturation logic is needed.
- Invariant when out_valid=1: lt_cnt+gt_cnt+eq_cnt <= WIN_LEN, with equality iff err_flag=0.
- rst_n asserted mid-window or mid-HOLD: immediate return to reset state; the partial window is discarded.

Test Plan:
- Basic window, WIN_LEN=8, no stalls:
  - Stimulus: comparator pairs (2,2),(22,444),(44444,555),(77777,1111),(88888,88888),(5,5),(5,5),(1,9), giving E,L,G,G,E,E,E,L.
  - Required: out_valid one cycle after the 8th accept; lt=2, gt=2, eq=4, eq_run_max=3, err=0.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 throughout.
  - Required: in_ready=0; outputs stable; no samples consumed. After out_ready=1, the next window counts start from the first post-handshake accept.
- Run across a gap:
  - Stimulus: 8 consecutive E samples with in_valid gaps between them.
  - Required: eq=8, eq_run_max=8. Gaps in in_valid do not break the run.
- Illegal flags:
  - Stimulus: sample 3 has L=1,E=1; sample 6 has all flags 0; the rest are G.
  - Required: gt=6, lt=0, eq=0, err_flag=1. The next window reports err_flag=0 when clean.
- Clear and reset:
  - Stimulus: clear pulse after 5 accepts, coincident with in_valid=1.
  - Required: the window restarts and needs 8 fresh accepts; the coincident sample is not counted.
  - Stimulus: rst_n low for 1 cycle during HOLD.
  - Required: out_valid=0 immediately (asynchronous); all outputs 0.
- Coincident close/clear:
  - Stimulus: clear asserted on the 8th accept.
  - Required: no out_valid; counts 0; state COLLECT.

Source files
------------

// File: rtl/cmp_window_stats.sv
// ============================================================================
// Module   : cmp_window_stats
// Brief    : Windowed statistics (L/G/E counts, longest E run) over comparator
//            results, delivered through a valid/ready result handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_window_stats #(
   parameter int WIN_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             L,
   input  logic             G,
   input  logic             E,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] eq_run_max,
   output logic             err_flag
);

   localparam logic [0:0]       c_COLLECT = 1'b0;
   localparam logic [0:0]       c_HOLD    = 1'b1;
   localparam logic [CNT_W-1:0] c_WIN_LEN = CNT_W'(WIN_LEN);
   localparam logic [CNT_W-1:0] c_ZERO    = '0;

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_idx;
   logic [CNT_W-1:0] r_lt;
   logic [CNT_W-1:0] r_gt;
   logic [CNT_W-1:0] r_eq;
   logic [CNT_W-1:0] r_cur_run;
   logic [CNT_W-1:0] r_run_max;
   logic             r_err;

   logic             w_onehot;
   logic [CNT_W-1:0] w_idx_nxt;
   logic [CNT_W-1:0] w_lt_nxt;
   logic [CNT_W-1:0] w_gt_nxt;
   logic [CNT_W-1:0] w_eq_nxt;
   logic [CNT_W-1:0] w_cur_run_nxt;
   logic [CNT_W-1:0] w_run_max_nxt;
   logic             w_err_nxt;
   logic             w_close;

   assign in_ready  = (r_state == c_COLLECT);
   assign out_valid = (r_state == c_HOLD);

   // Exactly one flag set; anything else is counted only as an error sample.
   assign w_onehot      = (L ^ G ^ E) & ~(L & G & E);
   assign w_idx_nxt     = r_idx + 1'b1;
   assign w_lt_nxt      = r_lt + {{(CNT_W-1){1'b0}}, (w_onehot & L)};
   assign w_gt_nxt      = r_gt + {{(CNT_W-1){1'b0}}, (w_onehot & G)};
   assign w_eq_nxt      = r_eq + {{(CNT_W-1){1'b0}}, (w_onehot & E)};
   assign w_cur_run_nxt = (w_onehot & E) ? (r_cur_run + 1'b1) : c_ZERO;
   assign w_run_max_nxt = (w_cur_run_nxt > r_run_max) ? w_cur_run_nxt : r_run_max;
   assign w_err_nxt     = r_err | ~w_onehot;
   assign w_close       = (w_idx_nxt == c_WIN_LEN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_COLLECT;
         r_idx      <= '0;
         r_lt       <= '0;
         r_gt       <= '0;
         r_eq       <= '0;
         r_cur_run  <= '0;
         r_run_max  <= '0;
         r_err      <= 1'b0;
         lt_cnt     <= '0;
         gt_cnt     <= '0;
         eq_cnt     <= '0;
         eq_run_max <= '0;
         err_flag   <= 1'b0;
      end else if (clear) begin
         r_state    <= c_COLLECT;
         r_idx      <= '0;
         r_lt       <= '0;
         r_gt       <= '0;
         r_eq       <= '0;
         r_cur_run  <= '0;
         r_run_max  <= '0;
         r_err      <= 1'b0;
         lt_cnt     <= '0;
         gt_cnt     <= '0;
         eq_cnt     <= '0;
         eq_run_max <= '0;
         err_flag   <= 1'b0;
      end else begin
         case (r_state)
            c_COLLECT: begin
               if (in_valid) begin
                  if (w_close) begin
                     // Publish the window including this last sample, then restart.
                     lt_cnt     <= w_lt_nxt;
                     gt_cnt     <= w_gt_nxt;
                     eq_cnt     <= w_eq_nxt;
                     eq_run_max <= w_run_max_nxt;
                     err_flag   <= w_err_nxt;
                     r_idx      <= '0;
                     r_lt       <= '0;
                     r_gt       <= '0;
                     r_eq       <= '0;
                     r_cur_run  <= '0;
                     r_run_max  <= '0;
                     r_err      <= 1'b0;
                     r_state    <= c_HOLD;
                  end else begin
                     r_idx      <= w_idx_nxt;
                     r_lt       <= w_lt_nxt;
                     r_gt       <= w_gt_nxt;
                     r_eq       <= w_eq_nxt;
                     r_cur_run  <= w_cur_run_nxt;
                     r_run_max  <= w_run_max_nxt;
                     r_err      <= w_err_nxt;
                  end
               end
            end
            default: begin
               if (out_ready) begin
                  r_state <= c_COLLECT;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cmp_window_stats.sv
// ============================================================================
// Module   : tb_cmp_window_stats
// Brief    : Directed self-checking bench for cmp_window_stats (WIN_LEN=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_window_stats;

   localparam int WIN_LEN = 8;
   localparam int CNT_W   = 8;

   // {L,G,E} encodings
   localparam logic [2:0] c_L  = 3'b100;
   localparam logic [2:0] c_G  = 3'b010;
   localparam logic [2:0] c_E  = 3'b001;
   localparam logic [2:0] c_LE = 3'b101;
   localparam logic [2:0] c_NO = 3'b000;

   logic             clk;
   logic             rst_n;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic             L, G, E;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] lt_cnt, gt_cnt, eq_cnt, eq_run_max;
   logic             err_flag;

   int vectors;
   int miscompares;

   cmp_window_stats #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .L          (L),
      .G          (G),
      .E          (E),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .lt_cnt     (lt_cnt),
      .gt_cnt     (gt_cnt),
      .eq_cnt     (eq_cnt),
      .eq_run_max (eq_run_max),
      .err_flag   (err_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic check_result(input string tag, input int lt, input int gt, input int eq,
                               input int run, input int err);
      check({tag, ".out_valid"}, int'(out_valid), 1);
      check({tag, ".in_ready"},  int'(in_ready), 0);
      check({tag, ".lt"},        int'(lt_cnt), lt);
      check({tag, ".gt"},        int'(gt_cnt), gt);
      check({tag, ".eq"},        int'(eq_cnt), eq);
      check({tag, ".run"},       int'(eq_run_max), run);
      check({tag, ".err"},       int'(err_flag), err);
   endtask

   // One accepted sample; DUT is in COLLECT so in_ready is already high.
   task automatic push(input logic [2:0] lge);
      in_valid = 1'b1;
      {L, G, E} = lge;
      @(posedge clk); #1;
      in_valid = 1'b0;
      {L, G, E} = 3'b000;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ".hs_out_valid"}, int'(out_valid), 0);
      check({tag, ".hs_in_ready"},  int'(in_ready), 1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      clear       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      {L, G, E}   = 3'b000;

      // Reset state
      #2;
      check("rst.out_valid", int'(out_valid), 0);
      check("rst.in_ready",  int'(in_ready), 1);
      check("rst.lt",        int'(lt_cnt), 0);
      check("rst.run",       int'(eq_run_max), 0);
      check("rst.err",       int'(err_flag), 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // Basic window: E,L,G,G,E,E,E,L
      push(c_E); push(c_L); push(c_G); push(c_G);
      push(c_E); push(c_E); push(c_E);
      check("basic.pre_close_valid", int'(out_valid), 0);
      push(c_L);
      check_result("basic", 2, 2, 4, 3, 0);

      // Back-pressure: G samples offered while held must not be consumed
      in_valid = 1'b1;
      {L, G, E} = c_G;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp.in_ready", int'(in_ready), 0);
         check("bp.lt_stable", int'(lt_cnt), 2);
      end
      check_result("bp_hold", 2, 2, 4, 3, 0);
      handshake("bp");
      in_valid = 1'b0;
      {L, G, E} = 3'b000;
      check("bp.retained_lt", int'(lt_cnt), 2);
      for (int i = 0; i < WIN_LEN; i++) push(c_L);
      check_result("bp_next", 8, 0, 0, 0, 0);
      handshake("bp_next");

      // Run across gaps
      for (int i = 0; i < WIN_LEN; i++) begin
         push(c_E);
         if (i != WIN_LEN - 1) idle(2);
      end
      check_result("gap", 0, 0, 8, 8, 0);
      handshake("gap");

      // Illegal flags on samples 3 and 6
      push(c_G); push(c_G); push(c_LE); push(c_G);
      push(c_G); push(c_NO); push(c_G); push(c_G);
      check_result("illegal", 0, 6, 0, 0, 1);
      handshake("illegal");
      push(c_L); push(c_L); push(c_E); push(c_E);
      push(c_G); push(c_E); push(c_E); push(c_E);
      check_result("clean", 2, 1, 5, 3, 0);
      handshake("clean");

      // Clear after 5 accepts, coincident with a valid sample
      for (int i = 0; i < 5; i++) push(c_G);
      in_valid = 1'b1;
      {L, G, E} = c_E;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      in_valid = 1'b0;
      {L, G, E} = 3'b000;
      check("clear.out_valid", int'(out_valid), 0);
      check("clear.lt_zeroed", int'(lt_cnt), 0);
      check("clear.eq_zeroed", int'(eq_cnt), 0);
      for (int i = 0; i < WIN_LEN - 1; i++) push(c_L);
      check("clear.restart_valid", int'(out_valid), 0);
      push(c_E);
      check_result("clear_win", 7, 0, 1, 1, 0);

      // Asynchronous reset during HOLD
      rst_n = 1'b0;
      #1;
      check("arst.out_valid", int'(out_valid), 0);
      check("arst.in_ready",  int'(in_ready), 1);
      check("arst.lt",        int'(lt_cnt), 0);
      check("arst.eq",        int'(eq_cnt), 0);
      check("arst.run",       int'(eq_run_max), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);

      // Clear coincident with the closing accept
      for (int i = 0; i < WIN_LEN - 1; i++) push(c_G);
      clear = 1'b1;
      push(c_G);
      clear = 1'b0;
      check("cc.out_valid", int'(out_valid), 0);
      check("cc.in_ready",  int'(in_ready), 1);
      check("cc.gt",        int'(gt_cnt), 0);
      for (int i = 0; i < WIN_LEN - 1; i++) push(c_E);
      check("cc.restart_valid", int'(out_valid), 0);
      push(c_E);
      check_result("cc_next", 0, 0, 8, 8, 0);
      handshake("cc_next");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
